// File: rtl/d_ip_apb_master_pkg.sv
// ---------------------------------------------------------------------------
// d_ip_apb_pkg
// Shared types and defaults for the APB3 requester d_ip_apb_master.
//   apb_mst_st_e : requester FSM states (IDLE / SETUP / ACCESS)
//   apb_rsp_t    : response slot contents (read data + error flag)
//   APB_DATA_WD  : width of the response data carried in apb_rsp_t
//   APB_TMO_CYC_DEF : default PREADY-low limit for the optional timeout
// ---------------------------------------------------------------------------
package d_ip_apb_pkg;

   localparam int APB_DATA_WD     = 32;
   localparam int APB_TMO_CYC_DEF = 255;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_mst_st_e;

   typedef struct packed {
      logic [APB_DATA_WD-1:0] rdata;
      logic                   err;
   } apb_rsp_t;

endpackage

// File: rtl/d_ip_apb_master_if.sv
// ---------------------------------------------------------------------------
// d_ip_apb_master_if
// Groups the command stream, the response stream and the APB3 bus of the
// requester into one bundle.
//   modport master : view of d_ip_apb_master (drives cmd_ready, rsp_*, busy,
//                    PSEL/PENABLE/PADDR/PWRITE/PWDATA; receives cmd_*,
//                    rsp_ready, PRDATA/PREADY/PSLVERR)
//   modport slave  : opposite view (command source, response sink and the
//                    APB peripheral side together)
// ---------------------------------------------------------------------------
interface d_ip_apb_master_if #(
   parameter int ADDR_WD = 12,
   parameter int DATA_WD = 32
);
   // command stream
   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_write;
   logic [ADDR_WD-1:0] cmd_addr;
   logic [DATA_WD-1:0] cmd_wdata;
   // response stream
   logic               rsp_valid;
   logic               rsp_ready;
   logic [DATA_WD-1:0] rsp_rdata;
   logic               rsp_err;
   logic               busy;
   // APB3 bus
   logic               PSEL;
   logic               PENABLE;
   logic [ADDR_WD-1:0] PADDR;
   logic               PWRITE;
   logic [DATA_WD-1:0] PWDATA;
   logic [DATA_WD-1:0] PRDATA;
   logic               PREADY;
   logic               PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA
   );

endinterface

// File: rtl/d_ip_apb_master.sv
// ---------------------------------------------------------------------------
// d_ip_apb_master
// APB3 requester: converts a valid/ready command stream into single APB
// transfers (one outstanding) and returns read data / error status on a
// valid/ready response stream. All APB outputs come straight from flops.
//
// Ports:
//   PCLK   : clock
//   PRESET : synchronous, active-high reset
//   bus    : d_ip_apb_master_if.master (cmd_*, rsp_*, busy, APB signals)
//
// Parameters: ADDR_WD, DATA_WD, TMO_CYC (>= 1, timeout build only).
// Build option: define D_IP_APB_MASTER_TIMEOUT_EN to terminate an ACCESS
// phase with rsp_err=1 after TMO_CYC consecutive PREADY-low cycles.
// ---------------------------------------------------------------------------
module d_ip_apb_master
   import d_ip_apb_pkg::*;
#(
   parameter int ADDR_WD = 12,
   parameter int DATA_WD = 32,
   parameter int TMO_CYC = APB_TMO_CYC_DEF
) (
   input  logic                PCLK,
   input  logic                PRESET,
   d_ip_apb_master_if.master   bus
);

   apb_mst_st_e        r_state;
   apb_mst_st_e        w_state_nxt;
   logic               w_cmd_ready;
   logic               w_accept;
   logic               w_done;
   logic               w_tmo_hit;

   logic               r_psel;
   logic               r_penable;
   logic               r_pwrite;
   logic [ADDR_WD-1:0] r_paddr;
   logic [DATA_WD-1:0] r_pwdata;
   logic               r_busy;
   logic               r_rsp_valid;
   apb_rsp_t           r_rsp;

`ifdef D_IP_APB_MASTER_TIMEOUT_EN
   localparam int TMO_WD = $clog2(TMO_CYC + 1);
   logic [TMO_WD-1:0] r_tmo_cnt;

   // PREADY-low cycle counter, restarted while in SETUP (i.e. on ACCESS entry)
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_tmo_cnt <= '0;
      end else if (r_state == SETUP) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == ACCESS) && !bus.PREADY) begin
         r_tmo_cnt <= r_tmo_cnt + TMO_WD'(1);
      end else begin
         r_tmo_cnt <= r_tmo_cnt;
      end
   end

   // The current cycle is the TMO_CYC-th PREADY-low cycle; PREADY high wins.
   assign w_tmo_hit = (r_state == ACCESS) && !bus.PREADY &&
                      (r_tmo_cnt == TMO_WD'(TMO_CYC - 1));
`else
   assign w_tmo_hit = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = SETUP;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SETUP: begin
            w_state_nxt = ACCESS;
         end
         ACCESS: begin
            if (bus.PREADY || w_tmo_hit) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = ACCESS;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // FSM output decode: handshake and transfer-end strobes
   always_comb begin
      w_cmd_ready = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            // a full slot still admits a command when it drains this cycle;
            // held low during reset so nothing is accepted then
            w_cmd_ready = !PRESET && (!r_rsp_valid || bus.rsp_ready);
         end
         ACCESS: begin
            w_done = bus.PREADY;
         end
         default: begin
            w_cmd_ready = 1'b0;
            w_done      = 1'b0;
         end
      endcase
   end

   assign w_accept = bus.cmd_valid && w_cmd_ready;

   // APB output registers, loaded from the next state so they match the FSM
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_busy    <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
      end else begin
         r_psel    <= (w_state_nxt != IDLE);
         r_penable <= (w_state_nxt == ACCESS);
         r_busy    <= (w_state_nxt != IDLE);
         if (w_accept) begin
            r_pwrite <= bus.cmd_write;
            r_paddr  <= bus.cmd_addr;
            r_pwdata <= bus.cmd_write ? bus.cmd_wdata : '0;
         end else begin
            r_pwrite <= r_pwrite;
            r_paddr  <= r_paddr;
            r_pwdata <= r_pwdata;
         end
      end
   end

   // Response slot: filled at transfer end, held until rsp_ready
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_rsp_valid <= 1'b0;
         r_rsp       <= '0;
      end else if (w_done) begin
         r_rsp_valid <= 1'b1;
         r_rsp.rdata <= r_pwrite ? '0 : APB_DATA_WD'(bus.PRDATA);
         r_rsp.err   <= bus.PSLVERR;
      end else if (w_tmo_hit) begin
         r_rsp_valid <= 1'b1;
         r_rsp.rdata <= '0;
         r_rsp.err   <= 1'b1;
      end else if (bus.rsp_ready) begin
         r_rsp_valid <= 1'b0;
         r_rsp       <= r_rsp;
      end else begin
         r_rsp_valid <= r_rsp_valid;
         r_rsp       <= r_rsp;
      end
   end

   assign bus.cmd_ready = w_cmd_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_rdata = DATA_WD'(r_rsp.rdata);
   assign bus.rsp_err   = r_rsp.err;
   assign bus.busy      = r_busy;
   assign bus.PSEL      = r_psel;
   assign bus.PENABLE   = r_penable;
   assign bus.PADDR     = r_paddr;
   assign bus.PWRITE    = r_pwrite;
   assign bus.PWDATA    = r_pwdata;

endmodule

// File: tb/tb_d_ip_apb_master.sv
// ---------------------------------------------------------------------------
// tb_d_ip_apb_master
// Directed bench for d_ip_apb_master with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too (registered) or 1 unit later (combinational cmd_ready).
// ---------------------------------------------------------------------------
module tb_d_ip_apb_master;

   logic PCLK = 1'b0;
   logic PRESET;
   int   n_tests = 0;
   int   n_fail  = 0;

   d_ip_apb_master_if #(.ADDR_WD(12), .DATA_WD(32)) bus ();

   d_ip_apb_master #(.ADDR_WD(12), .DATA_WD(32), .TMO_CYC(4)) u_dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .bus    (bus.master)
   );

   always #5 PCLK = ~PCLK;

   // one comparison: count it and report a mismatch
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic set_cmd(input logic v, input logic wr, input logic [11:0] a, input logic [31:0] d);
      bus.cmd_valid = v;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      PRESET = 1'b1;
      set_cmd(1'b0, 1'b0, 12'h000, 32'h0);
      bus.rsp_ready = 1'b0;
      bus.PRDATA    = 32'h0;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;
      repeat (2) tick();

      // ---- reset state
      chk("rst_psel",      32'(bus.PSEL),      32'd0);
      chk("rst_penable",   32'(bus.PENABLE),   32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      PRESET = 1'b0;
      #1;
      chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

      // ---- write, zero wait states
      set_cmd(1'b1, 1'b1, 12'h010, 32'hA5A5_0001);
      bus.PREADY    = 1'b1;
      bus.rsp_ready = 1'b1;
      tick();                                   // accept edge
      set_cmd(1'b0, 1'b0, 12'h000, 32'h0);
      chk("wr_setup_psel",    32'(bus.PSEL),      32'd1);
      chk("wr_setup_penable", 32'(bus.PENABLE),   32'd0);
      chk("wr_paddr",         32'(bus.PADDR),     32'h010);
      chk("wr_pwdata",        bus.PWDATA,         32'hA5A5_0001);
      chk("wr_pwrite",        32'(bus.PWRITE),    32'd1);
      chk("wr_busy",          32'(bus.busy),      32'd1);
      #1;
      chk("wr_setup_cmd_rdy", 32'(bus.cmd_ready), 32'd0);
      tick();
      chk("wr_acc_psel",      32'(bus.PSEL),      32'd1);
      chk("wr_acc_penable",   32'(bus.PENABLE),   32'd1);
      chk("wr_acc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      tick();
      chk("wr_rsp_valid",     32'(bus.rsp_valid), 32'd1);
      chk("wr_rsp_err",       32'(bus.rsp_err),   32'd0);
      chk("wr_rsp_rdata",     bus.rsp_rdata,      32'h0);
      chk("wr_end_psel",      32'(bus.PSEL),      32'd0);
      chk("wr_end_penable",   32'(bus.PENABLE),   32'd0);
      chk("wr_end_busy",      32'(bus.busy),      32'd0);
      tick();
      chk("wr_drained",       32'(bus.rsp_valid), 32'd0);

      // ---- read, 3 wait states
      set_cmd(1'b1, 1'b0, 12'h004, 32'hFFFF_FFFF);
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'h1234_5678;
      tick();
      set_cmd(1'b0, 1'b0, 12'h000, 32'h0);
      chk("rd_pwdata_zero", bus.PWDATA, 32'h0);
      tick();                                   // ACCESS cycle 1
      for (int i = 0; i < 3; i++) begin
         chk("rd_wait_psel",    32'(bus.PSEL),      32'd1);
         chk("rd_wait_penable", 32'(bus.PENABLE),   32'd1);
         chk("rd_wait_paddr",   32'(bus.PADDR),     32'h004);
         chk("rd_wait_pwrite",  32'(bus.PWRITE),    32'd0);
         chk("rd_wait_rsp",     32'(bus.rsp_valid), 32'd0);
         tick();
      end
      chk("rd_acc4_penable", 32'(bus.PENABLE), 32'd1);
      bus.PREADY = 1'b1;                        // ACCESS cycle 4 completes
      tick();
      chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rd_rsp_rdata", bus.rsp_rdata,      32'h1234_5678);
      chk("rd_rsp_err",   32'(bus.rsp_err),   32'd0);
      chk("rd_end_psel",  32'(bus.PSEL),      32'd0);
      tick();

      // ---- slave error, then next command accepted with simultaneous drain
      set_cmd(1'b1, 1'b0, 12'h008, 32'h0);
      bus.PSLVERR = 1'b1;
      bus.PRDATA  = 32'hDEAD_BEEF;
      tick();
      set_cmd(1'b0, 1'b0, 12'h000, 32'h0);
      tick();
      tick();
      bus.PSLVERR = 1'b0;
      chk("err_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("err_rsp_err",   32'(bus.rsp_err),   32'd1);
      chk("err_rsp_rdata", bus.rsp_rdata,      32'hDEAD_BEEF);
      set_cmd(1'b1, 1'b0, 12'h00C, 32'h0);
      bus.PRDATA = 32'hCAFE_0001;
      #1;
      chk("err_next_cmd_rdy", 32'(bus.cmd_ready), 32'd1);
      tick();
      set_cmd(1'b0, 1'b0, 12'h000, 32'h0);
      bus.rsp_ready = 1'b0;
      chk("err_next_psel",  32'(bus.PSEL),      32'd1);
      chk("err_next_paddr", 32'(bus.PADDR),     32'h00C);
      chk("err_drained",    32'(bus.rsp_valid), 32'd0);
      tick();
      tick();
      chk("next_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("next_rsp_err",   32'(bus.rsp_err),   32'd0);
      chk("next_rsp_rdata", bus.rsp_rdata,      32'hCAFE_0001);

      // ---- response backpressure with a command waiting
      set_cmd(1'b1, 1'b1, 12'h020, 32'h0000_0055);
      bus.PRDATA = 32'h0BAD_0BAD;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_rsp_rdata", bus.rsp_rdata,      32'hCAFE_0001);
         chk("bp_psel",      32'(bus.PSEL),      32'd0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp_release_cmd_rdy", 32'(bus.cmd_ready), 32'd1);
      tick();
      set_cmd(1'b0, 1'b0, 12'h000, 32'h0);
      chk("bp_acc_psel",   32'(bus.PSEL),      32'd1);
      chk("bp_acc_paddr",  32'(bus.PADDR),     32'h020);
      chk("bp_acc_pwdata", bus.PWDATA,         32'h0000_0055);
      chk("bp_rsp_gone",   32'(bus.rsp_valid), 32'd0);
      tick();
      tick();
      chk("bp_wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_wr_rsp_rdata", bus.rsp_rdata,      32'h0);
      tick();

      // ---- reset during ACCESS with PREADY low
      set_cmd(1'b1, 1'b0, 12'h030, 32'h0);
      bus.PREADY = 1'b0;
      tick();
      set_cmd(1'b0, 1'b0, 12'h000, 32'h0);
      tick();
      chk("rst_acc_penable", 32'(bus.PENABLE), 32'd1);
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      bus.PREADY = 1'b1;
      chk("rst_mid_psel",      32'(bus.PSEL),      32'd0);
      chk("rst_mid_penable",   32'(bus.PENABLE),   32'd0);
      chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_mid_busy",      32'(bus.busy),      32'd0);
      tick();
      chk("rst_mid_no_rsp",    32'(bus.rsp_valid), 32'd0);
      chk("rst_mid_cmd_rdy",   32'(bus.cmd_ready), 32'd1);

      // ---- PREADY held low (timeout when enabled, otherwise wait forever)
      set_cmd(1'b1, 1'b0, 12'h040, 32'h0);
      bus.PREADY = 1'b0;
      bus.PRDATA = 32'hFFFF_FFFF;
      tick();
      set_cmd(1'b0, 1'b0, 12'h000, 32'h0);
      tick();                                   // ACCESS cycle 1
      for (int i = 0; i < 3; i++) begin
         chk("tmo_wait_penable", 32'(bus.PENABLE),   32'd1);
         chk("tmo_wait_rsp",     32'(bus.rsp_valid), 32'd0);
         tick();
      end
      tick();                                   // end of 4th low cycle
`ifdef D_IP_APB_MASTER_TIMEOUT_EN
      chk("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("tmo_rsp_err",   32'(bus.rsp_err),   32'd1);
      chk("tmo_rsp_rdata", bus.rsp_rdata,      32'h0);
      chk("tmo_psel",      32'(bus.PSEL),      32'd0);
      chk("tmo_penable",   32'(bus.PENABLE),   32'd0);
      tick();
`else
      chk("notmo_penable",   32'(bus.PENABLE),   32'd1);
      chk("notmo_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      repeat (10) tick();
      chk("notmo_still_busy", 32'(bus.busy), 32'd1);
      bus.PREADY = 1'b1;
      tick();
      chk("notmo_rsp_valid2", 32'(bus.rsp_valid), 32'd1);
      chk("notmo_rsp_rdata",  bus.rsp_rdata,      32'hFFFF_FFFF);
      chk("notmo_rsp_err",    32'(bus.rsp_err),   32'd0);
      tick();
`endif
      chk("final_rsp_drained", 32'(bus.rsp_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/d_ip_apb_master.md
Name: d_ip_apb_master

Overview:
- APB3 requester (initiator) that turns a simple valid/ready command stream into APB transfers toward peripherals such as the UART.
- Sits between an internal bus bridge or DMA front-end and the APB slave fabric.
- Returns read data and error status on a valid/ready response stream.
- Single outstanding transfer; fully registered APB outputs.

Parameters:
- ADDR_WD, 12, APB address width.
- DATA_WD, 32, APB data width.
- TMO_CYC, 255, maximum PREADY-low cycles in ACCESS before forced termination (used only with timeout feature); minimum 1.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WD  target address.
- cmd_wdata  in  DATA_WD  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WD  read data (0 for writes).
- rsp_err  out  1  PSLVERR or timeout.
- busy  out  1  transfer in SETUP or ACCESS.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_WD  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WD  APB write data.
- PRDATA  in  DATA_WD  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Interface: one clock, PCLK. Reset PRESET is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, response slot empty.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1 when the response slot is empty, or when rsp_valid && rsp_ready in the same cycle.
  - On accept, register cmd_addr, cmd_write and cmd_wdata (cmd_wdata is registered for writes only; otherwise PWDATA = 0), then go to SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA stable. Always advances to ACCESS after 1 cycle.
- ACCESS:
  - PSEL=1, PENABLE=1; hold all APB outputs while PREADY=0.
  - When PREADY=1, capture PRDATA (reads; writes give 0) into rsp_rdata and PSLVERR into rsp_err, set rsp_valid, and go to IDLE.
  - PSEL and PENABLE are 0 in the following cycle.
- cmd_ready is 0 in SETUP and ACCESS. busy = (state != IDLE).
- Latency: command accepted at edge T -> PSEL at T+1 -> PENABLE at T+2. With PREADY high at T+2, rsp_valid at T+3. Peak throughput is 1 transfer per 3 cycles.
- Response slot:
  - rsp_valid stays high, with rsp_rdata and rsp_err stable, until rsp_ready.
  - While the slot is full and not being drained, no new command is accepted.
  - Simultaneous drain and new accept in IDLE is allowed.
- PSLVERR is sampled only in ACCESS with PREADY=1; it is ignored otherwise.
- Reset mid-transfer: the next edge forces IDLE, drops PSEL/PENABLE to 0 and discards any pending response. No response is generated for the aborted transfer.
- cmd_* inputs are ignored when cmd_ready=0.

Optional Feature:
- Macro: D_IP_APB_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A counter (width clog2(TMO_CYC+1)) clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TMO_CYC with PREADY still 0, the transfer terminates: rsp_valid=1, rsp_err=1, rsp_rdata=0, then IDLE with PSEL/PENABLE low.
  - PREADY=1 in the same cycle the limit is reached wins, giving a normal completion.
- Without the macro: no counter is present, and ACCESS waits indefinitely for PREADY.

Decomposition:
- Shared package d_ip_apb_pkg holds:
  - state enum apb_mst_st_e {IDLE, SETUP, ACCESS};
  - struct apb_rsp_t {rdata, err};
  - localparam for the default timeout.
- Single module. The timeout counter is inline under the macro; no sub-module is warranted.

Test Plan:
- Write, zero wait states:
  - Stimulus: cmd write addr 0x010, data 0xA5A5_0001; PREADY=1.
  - Response: PSEL at T+1, PENABLE at T+2, PADDR=0x010, PWDATA=0xA5A5_0001; rsp_valid at T+3 with rsp_err=0, rsp_rdata=0.
- Read, 3 wait states:
  - Stimulus: read addr 0x004; PREADY low for 3 ACCESS cycles; PRDATA=0x1234_5678.
  - Response: APB outputs held stable 4 ACCESS cycles; rsp_rdata=0x1234_5678, rsp_err=0.
- Slave error:
  - Stimulus: read with PSLVERR=1 and PREADY=1.
  - Response: rsp_err=1; next command still accepted normally.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles while cmd_valid is held high.
  - Response: cmd_ready=0 and rsp_valid/rsp_rdata stable throughout; cmd accepted in the same cycle rsp_ready rises.
- Reset in ACCESS:
  - Stimulus: PRESET=1 for 1 cycle during ACCESS with PREADY=0.
  - Response: next cycle PSEL=0, PENABLE=0, rsp_valid=0, busy=0.
- Timeout (macro defined, TMO_CYC=4):
  - Stimulus: PREADY held 0.
  - Response: rsp_valid with rsp_err=1, rsp_rdata=0 after 4 wait cycles; PSEL drops.
